// File: rtl/cbus_arbiter.sv
// -----------------------------------------------------------------------------
// cbus_arbiter
//
// Arbitrates a single shared bus (creq/cresp) between an instruction-fetch
// requester (ireq/iresp) and a memory-stage data requester (dreq/dresp).
// One transaction is in flight at a time. The grant is held until the bus
// reports cresp_last, and an IDLE cycle always separates two grants.
//
// Optional build macro:
//   CBUS_ARB_RR_EN  when defined, contention is resolved round-robin with a
//                   one-bit last-grant flop. When undefined, data always wins
//                   contention and that flop does not exist.
//
// Parameters:
//   ADDR_W  request address width
//   DATA_W  data width (strobe width is DATA_W/8)
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   ireq_valid/addr/size fetch request, held until iresp_data_ok
//   iresp_data_ok/data   fetch completion pulse and read data
//   dreq_valid/addr/size/strobe/wdata
//                        data request, held until dresp_data_ok;
//                        strobe == 0 means a load
//   dresp_data_ok/data   data completion pulse and load data
//   creq_valid/is_write/addr/size/strobe/data
//                        shared-bus request, muxed from the granted side
//   cresp_last/data      shared-bus completion and read data
// -----------------------------------------------------------------------------
module cbus_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                ireq_valid,
  input  logic [ADDR_W-1:0]   ireq_addr,
  input  logic [2:0]          ireq_size,
  output logic                iresp_data_ok,
  output logic [DATA_W-1:0]   iresp_data,

  input  logic                dreq_valid,
  input  logic [ADDR_W-1:0]   dreq_addr,
  input  logic [2:0]          dreq_size,
  input  logic [DATA_W/8-1:0] dreq_strobe,
  input  logic [DATA_W-1:0]   dreq_wdata,
  output logic                dresp_data_ok,
  output logic [DATA_W-1:0]   dresp_data,

  output logic                creq_valid,
  output logic                creq_is_write,
  output logic [ADDR_W-1:0]   creq_addr,
  output logic [2:0]          creq_size,
  output logic [DATA_W/8-1:0] creq_strobe,
  output logic [DATA_W-1:0]   creq_data,
  input  logic                cresp_last,
  input  logic [DATA_W-1:0]   cresp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Winner when both sides request in the same IDLE cycle (1 = data).
  logic contend_data;

`ifdef CBUS_ARB_RR_EN
  // Remembers which side won the most recent grant (1 = fetch, 0 = data) so
  // contention goes to the other side next time.
  logic last_fetch;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_fetch <= 1'b0;
    end else if (state == IDLE && state_next == IGNT) begin
      last_fetch <= 1'b1;
    end else if (state == IDLE && state_next == DGNT) begin
      last_fetch <= 1'b0;
    end
  end

  assign contend_data = last_fetch;
`else
  assign contend_data = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: grants are only issued from IDLE, and a grant is
  // released solely by cresp_last, whatever the requesters do meanwhile.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ireq_valid && dreq_valid) begin
          state_next = contend_data ? DGNT : IGNT;
        end else if (dreq_valid) begin
          state_next = DGNT;
        end else if (ireq_valid) begin
          state_next = IGNT;
        end
      end
      IGNT, DGNT: begin
        if (cresp_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: payload comes straight from the granted requester; IDLE
  // drives zeros so a stray cresp_last there produces no completion.
  always_comb begin
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_addr     = '0;
    creq_size     = '0;
    creq_strobe   = '0;
    creq_data     = '0;
    iresp_data_ok = 1'b0;
    dresp_data_ok = 1'b0;
    iresp_data    = '0;
    dresp_data    = '0;

    case (state)
      IGNT: begin
        creq_valid    = 1'b1;
        creq_addr     = ireq_addr;
        creq_size     = ireq_size;
        iresp_data_ok = cresp_last;
      end
      DGNT: begin
        creq_valid    = 1'b1;
        creq_is_write = |dreq_strobe;
        creq_addr     = dreq_addr;
        creq_size     = dreq_size;
        creq_strobe   = dreq_strobe;
        creq_data     = dreq_wdata;
        dresp_data_ok = cresp_last;
      end
      default: begin
      end
    endcase

    // Read data is a straight pass-through, forced to zero while in reset so
    // every output is quiet during reset.
    if (resetn) begin
      iresp_data = cresp_data;
      dresp_data = cresp_data;
    end
  end

endmodule
